z80_ixiy_imm_seq: RTL and testbench

Z80_IXIY_IMM_SEQ -- requirements
Module: z80_ixiy_imm_seq

---
 rtl/z80_ixiy_imm_seq_pkg.sv | 20 ++
 rtl/z80_ixiy_imm_seq_if.sv | 30 +++
 rtl/z80_tstate_counter.sv | 36 +++
 rtl/z80_ixiy_imm_seq.sv | 141 ++++++++++++++
 tb/tb_z80_ixiy_imm_seq.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/z80_ixiy_imm_seq_pkg.sv
// Shared constants for the DD/FD 21 nn nn (LD IX/IY,nn) sequencer.
// CYCLE_* values mirror the encodings of the common z80.vh header.
package z80_ixiy_imm_seq_pkg;

  localparam logic [2:0] CYCLE_NONE     = 3'd0;
  localparam logic [2:0] CYCLE_M1       = 3'd1;
  localparam logic [2:0] CYCLE_RDWR_MEM = 3'd2;

  localparam logic [7:0] PFX_IX    = 8'hDD;
  localparam logic [7:0] PFX_IY    = 8'hFD;
  localparam logic [7:0] OPC_LD_NN = 8'h21;

  localparam logic [2:0] T_LEN_M1  = 3'd4;
  localparam logic [2:0] T_LEN_MEM = 3'd3;

  function automatic logic is_index_prefix(input logic [7:0] b);
    return (b == PFX_IX) || (b == PFX_IY);
  endfunction

endpackage

// File: rtl/z80_ixiy_imm_seq_if.sv
// Request, memory-bus and register-write signals of the sequencer.
// master = requester/memory side, slave = the sequencer itself.
interface z80_ixiy_imm_seq_if;
  logic        start;
  logic [15:0] ip_in;
  logic        busy;
  logic [2:0]  mcycle_type;
  logic [2:0]  tstate;
  logic [15:0] bus_addr;
  logic        wait_n;
  logic [7:0]  bus_data;
  logic        reg_we;
  logic        reg_sel_iy;
  logic [15:0] reg_wdata;
  logic [15:0] ip_out;
  logic        done;
  logic        illegal;

  modport master (
    output start, ip_in, wait_n, bus_data,
    input  busy, mcycle_type, tstate, bus_addr, reg_we, reg_sel_iy,
           reg_wdata, ip_out, done, illegal
  );

  modport slave (
    input  start, ip_in, wait_n, bus_data,
    output busy, mcycle_type, tstate, bus_addr, reg_we, reg_sel_iy,
           reg_wdata, ip_out, done, illegal
  );
endinterface

// File: rtl/z80_tstate_counter.sv
// T-state counter for one M-cycle: counts 1..len, holds in T2 while wait_n=0,
// returns to 0 after the last T-state unless a new M-cycle is loaded.
module z80_tstate_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [2:0] i_len,
  input  logic       i_wait_n,
  output logic [2:0] o_tstate,
  output logic       o_last
);

  logic [2:0] r_tstate;
  logic [2:0] r_len;
  logic       w_hold;

  assign w_hold   = (r_tstate == 3'd2) && !i_wait_n;
  assign o_last   = (r_tstate != 3'd0) && (r_tstate == r_len);
  assign o_tstate = r_tstate;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tstate <= 3'd0;
      r_len    <= 3'd0;
    end else if (i_load) begin
      r_tstate <= 3'd1;
      r_len    <= i_len;
    end else if (o_last) begin
      r_tstate <= 3'd0;
    end else if (r_tstate != 3'd0 && !w_hold) begin
      r_tstate <= r_tstate + 3'd1;
    end
  end

endmodule

// File: rtl/z80_ixiy_imm_seq.sv
// Executes one DD/FD 21 nn nn (LD IX,nn / LD IY,nn): two opcode fetches, two
// operand reads, then a one-cycle register write or a one-cycle abort.
module z80_ixiy_imm_seq
  import z80_ixiy_imm_seq_pkg::*;
(
  input logic               clk,
  input logic               reset_n,
  z80_ixiy_imm_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_PFX, S_OPC, S_RDLO, S_RDHI, S_WB, S_ABT
  } state_e;

  state_e      r_state, w_state_nxt;
  logic [15:0] r_ip;
  logic [15:0] r_nn;
  logic [15:0] r_abt_ip;
  logic [7:0]  r_byte;
  logic        r_iy;

  logic        w_load;
  logic [2:0]  w_len;
  logic [2:0]  w_tstate;
  logic        w_last;
  logic        w_capture;
  logic [15:0] w_addr;

  z80_tstate_counter u_tcnt (
    .clk      (clk),
    .rst_n    (reset_n),
    .i_load   (w_load),
    .i_len    (w_len),
    .i_wait_n (bus.wait_n),
    .o_tstate (w_tstate),
    .o_last   (w_last)
  );

  // Read data is valid on the edge that ends T2 without a pending wait.
  assign w_capture = (w_tstate == 3'd2) && bus.wait_n;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_len       = T_LEN_M1;
    unique case (r_state)
      S_IDLE: if (bus.start) begin
        w_state_nxt = S_PFX;
        w_load      = 1'b1;
      end
      S_PFX: if (w_last) begin
        if (is_index_prefix(r_byte)) begin
          w_state_nxt = S_OPC;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_ABT;
        end
      end
      S_OPC: if (w_last) begin
        if (r_byte == OPC_LD_NN) begin
          w_state_nxt = S_RDLO;
          w_load      = 1'b1;
          w_len       = T_LEN_MEM;
        end else begin
          w_state_nxt = S_ABT;
        end
      end
      S_RDLO: if (w_last) begin
        w_state_nxt = S_RDHI;
        w_load      = 1'b1;
        w_len       = T_LEN_MEM;
      end
      S_RDHI:  if (w_last) w_state_nxt = S_WB;
      S_WB:    w_state_nxt = S_IDLE;
      S_ABT:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_addr          = 16'h0000;
    bus.mcycle_type = CYCLE_NONE;
    bus.reg_we      = 1'b0;
    bus.reg_sel_iy  = 1'b0;
    bus.reg_wdata   = 16'h0000;
    bus.ip_out      = 16'h0000;
    bus.done        = 1'b0;
    bus.illegal     = 1'b0;
    unique case (r_state)
      S_PFX:  begin w_addr = r_ip;          bus.mcycle_type = CYCLE_M1;       end
      S_OPC:  begin w_addr = r_ip + 16'd1;  bus.mcycle_type = CYCLE_M1;       end
      S_RDLO: begin w_addr = r_ip + 16'd2;  bus.mcycle_type = CYCLE_RDWR_MEM; end
      S_RDHI: begin w_addr = r_ip + 16'd3;  bus.mcycle_type = CYCLE_RDWR_MEM; end
      S_WB: begin
        bus.reg_we     = 1'b1;
        bus.reg_sel_iy = r_iy;
        bus.reg_wdata  = r_nn;
        bus.ip_out     = r_ip + 16'd4;
        bus.done       = 1'b1;
      end
      S_ABT: begin
        bus.ip_out  = r_abt_ip;
        bus.done    = 1'b1;
        bus.illegal = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.bus_addr = w_addr;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.tstate   = w_tstate;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_ip     <= 16'h0000;
      r_nn     <= 16'h0000;
      r_abt_ip <= 16'h0000;
      r_byte   <= 8'h00;
      r_iy     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && bus.start) r_ip <= bus.ip_in;
      if (w_capture) begin
        unique case (r_state)
          S_PFX, S_OPC: r_byte     <= bus.bus_data;
          S_RDLO:       r_nn[7:0]  <= bus.bus_data;
          S_RDHI:       r_nn[15:8] <= bus.bus_data;
          default: ;
        endcase
      end
      // An abort reports the address just past the byte that was rejected.
      if ((r_state == S_PFX || r_state == S_OPC) && w_last)
        r_abt_ip <= w_addr + 16'd1;
      if (r_state == S_PFX && w_last) r_iy <= (r_byte == PFX_IY);
    end
  end

endmodule

// File: tb/tb_z80_ixiy_imm_seq.sv
// Scoreboard bench: stimulus pushes expected M-cycles and completions, a
// negedge monitor pops and compares them as the sequencer presents them.
module tb_z80_ixiy_imm_seq;
  import z80_ixiy_imm_seq_pkg::*;

  typedef struct {
    int          cyc;
    logic        ill;
    logic        we;
    logic        sel;
    logic [15:0] wdata;
    logic [15:0] ipo;
  } done_t;

  typedef struct {
    logic [15:0] addr;
    logic [2:0]  typ;
    int          t2;
  } mcyc_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  done_t done_q[$];
  mcyc_t mcyc_q[$];
  logic [7:0] mem [0:65535];

  z80_ixiy_imm_seq_if bus ();

  z80_ixiy_imm_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder; garbage on the data bus while a wait is pending.
  always_comb bus.bus_data = bus.wait_n ? mem[bus.bus_addr] : 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  done_t d;
  mcyc_t m;
  int    t2_cnt;
  int    t2_exp;
  logic  t2_pend = 1'b0;

  always @(negedge clk) begin
    if (!reset_n) begin
      t2_pend = 1'b0;
    end else begin
      if (bus.done) begin
        if (done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          d = done_q.pop_front();
          check("done_cycle", cyc, d.cyc);
          check("illegal", bus.illegal, d.ill);
          check("reg_we", bus.reg_we, d.we);
          if (d.we) begin
            check("reg_sel_iy", bus.reg_sel_iy, d.sel);
            check("reg_wdata", bus.reg_wdata, d.wdata);
          end
          check("ip_out", bus.ip_out, d.ipo);
          check("done_tstate", bus.tstate, 0);
          check("done_mcycle", bus.mcycle_type, CYCLE_NONE);
        end
      end else if (bus.reg_we) begin
        check("stray_reg_we", 1, 0);
      end
      if (bus.tstate == 3'd1) begin
        if (mcyc_q.size() == 0) begin
          check("unexpected_mcycle", 1, 0);
        end else begin
          m = mcyc_q.pop_front();
          check("bus_addr", bus.bus_addr, m.addr);
          check("mcycle_type", bus.mcycle_type, m.typ);
          check("busy", bus.busy, 1);
          t2_pend = 1'b1;
          t2_cnt  = 0;
          t2_exp  = m.t2;
        end
      end else if (bus.tstate == 3'd2) begin
        t2_cnt++;
      end else if (bus.tstate == 3'd3 && t2_pend) begin
        check("t2_length", t2_cnt, t2_exp);
        t2_pend = 1'b0;
      end
    end
  end

  task automatic load_mem(input logic [15:0] ip, input logic [7:0] b0, b1, b2, b3);
    logic [15:0] a;
    a = ip;          mem[a] = b0;
    a = ip + 16'd1;  mem[a] = b1;
    a = ip + 16'd2;  mem[a] = b2;
    a = ip + 16'd3;  mem[a] = b3;
  endtask

  task automatic push_cycles(input logic [15:0] ip, input int n, input int waits);
    mcyc_t r;
    for (int i = 0; i < n; i++) begin
      r.addr = ip + 16'(i);
      r.typ  = (i < 2) ? CYCLE_M1 : CYCLE_RDWR_MEM;
      r.t2   = (i == 2) ? 1 + waits : 1;
      mcyc_q.push_back(r);
    end
  endtask

  task automatic push_done(input int c, input logic ill, input logic sel,
                           input logic [15:0] wdata, input logic [15:0] ipo);
    done_t e;
    e.cyc = c; e.ill = ill; e.we = !ill; e.sel = sel; e.wdata = wdata; e.ipo = ipo;
    done_q.push_back(e);
  endtask

  // Waits (bounded) until every pushed completion has been seen.
  task automatic drain();
    int n;
    n = 0;
    while (done_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", done_q.size(), 0);
    if (done_q.size() != 0) begin
      done_q.delete();
      mcyc_q.delete();
    end
  endtask

  // Entered at posedge+1; the acceptance edge is the next posedge.
  task automatic run(input logic [15:0] ip, input logic [7:0] b0, b1, b2, b3,
                     input int ncyc, input logic ill, input logic sel,
                     input logic [15:0] wdata, input logic [15:0] ipo, input int waits);
    int a, tsum;
    load_mem(ip, b0, b1, b2, b3);
    a    = cyc + 1;
    tsum = 0;
    for (int i = 0; i < ncyc; i++) tsum += (i < 2) ? 4 : 3;
    push_cycles(ip, ncyc, waits);
    push_done(a + tsum + waits, ill, sel, wdata, ipo);
    bus.start = 1'b1;
    bus.ip_in = ip;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (waits > 0) begin
      repeat (9) @(posedge clk);
      #1 bus.wait_n = 1'b0;
      repeat (waits) @(posedge clk);
      #1 bus.wait_n = 1'b1;
    end
    drain();
  endtask

  initial begin
    int a;
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.ip_in   = 16'h0000;
    bus.wait_n  = 1'b1;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_tstate", bus.tstate, 0);
    check("rst_mcycle", bus.mcycle_type, CYCLE_NONE);
    check("rst_done", bus.done, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run(16'h1000, 8'hFD, 8'h21, 8'h34, 8'h12, 4, 1'b0, 1'b1, 16'h1234, 16'h1004, 0);
    run(16'hFFFE, 8'hDD, 8'h21, 8'hCD, 8'hAB, 4, 1'b0, 1'b0, 16'hABCD, 16'h0002, 0);
    run(16'h1000, 8'hFD, 8'h21, 8'h34, 8'h12, 4, 1'b0, 1'b1, 16'h1234, 16'h1004, 2);
    run(16'h2000, 8'hDD, 8'h22, 8'h00, 8'h00, 2, 1'b1, 1'b0, 16'h0000, 16'h2002, 0);
    run(16'h2100, 8'hED, 8'h21, 8'h00, 8'h00, 1, 1'b1, 1'b0, 16'h0000, 16'h2101, 0);
    run(16'hFFFF, 8'hDD, 8'h00, 8'h00, 8'h00, 2, 1'b1, 1'b0, 16'h0000, 16'h0001, 0);

    // Reset pulse during RDHI T2: instruction discarded
    load_mem(16'h4000, 8'hFD, 8'h21, 8'hEF, 8'hBE);
    push_cycles(16'h4000, 4, 0);
    bus.start = 1'b1;
    bus.ip_in = 16'h4000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_reg_we", bus.reg_we, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_illegal", bus.illegal, 0);
    check("mid_rst_tstate", bus.tstate, 0);
    check("mid_rst_mcycle", bus.mcycle_type, CYCLE_NONE);
    check("mid_rst_bus_addr", bus.bus_addr, 16'h0000);
    check("mid_rst_reg_wdata", bus.reg_wdata, 16'h0000);
    check("mid_rst_reg_sel_iy", bus.reg_sel_iy, 0);
    check("mid_rst_ip_out", bus.ip_out, 16'h0000);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_mcycle_q", mcyc_q.size(), 0);
    run(16'h4000, 8'hFD, 8'h21, 8'hEF, 8'hBE, 4, 1'b0, 1'b1, 16'hBEEF, 16'h4004, 0);

    // start held through one instruction and the following IDLE cycle
    load_mem(16'h3000, 8'hDD, 8'h21, 8'h78, 8'h56);
    a = cyc + 1;
    push_cycles(16'h3000, 4, 0);
    push_done(a + 14, 1'b0, 1'b0, 16'h5678, 16'h3004);
    push_cycles(16'h3000, 4, 0);
    push_done(a + 30, 1'b0, 1'b0, 16'h5678, 16'h3004);
    bus.start = 1'b1;
    bus.ip_in = 16'h3000;
    repeat (17) @(posedge clk);
    #1 bus.start = 1'b0;
    drain();

    repeat (4) @(posedge clk);
    #1;
    check("final_mcycle_q", mcyc_q.size(), 0);
    check("final_done_q", done_q.size(), 0);
    check("final_busy", bus.busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
